// File: rtl/mem_sram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_sram_pkg
// Description : Shared types and helpers for the SRAM read-modify-write front end.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_sram_pkg;

    localparam int unsigned c_RMW_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RMW_WAIT = 2'd1,
        RMW_WR   = 2'd2
    } rmw_state_e;

    typedef enum logic [1:0] {
        ReqRead   = 2'd0,
        ReqFullWr = 2'd1,
        ReqNullWr = 2'd2,
        ReqPartWr = 2'd3
    } req_class_e;

    // Takes the mask already reduced, so the helper stays independent of Dw.
    function automatic req_class_e classify_req(input logic we,
                                                input logic mask_ones,
                                                input logic mask_zero);
        req_class_e cls;
        if (!we) begin
            cls = ReqRead;
        end else if (mask_ones) begin
            cls = ReqFullWr;
        end else if (mask_zero) begin
            cls = ReqNullWr;
        end else begin
            cls = ReqPartWr;
        end
        return cls;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_sram_lat_pipe.sv
`default_nettype none
// ============================================================================
// Module      : mem_sram_lat_pipe
// Description : Fixed-depth valid/tag shift register tracking macro read returns.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_sram_lat_pipe #(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned TAG_W = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    output logic [TAG_W-1:0] o_tag
);

    logic [DEPTH-1:0]            r_valid;
    logic [DEPTH-1:0][TAG_W-1:0] r_tag;

    generate
        if (DEPTH == 1) begin : g_single
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_valid <= '0;
                    r_tag   <= '0;
                end else begin
                    r_valid <= i_valid;
                    r_tag   <= i_tag;
                end
            end
        end else begin : g_shift
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_valid <= '0;
                    r_tag   <= '0;
                end else begin
                    r_valid <= {r_valid[DEPTH-2:0], i_valid};
                    r_tag   <= {r_tag[DEPTH-2:0], i_tag};
                end
            end
        end
    endgenerate

    assign o_valid = r_valid[DEPTH-1];
    assign o_tag   = r_tag[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/mem_sram_rmw_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_sram_rmw_ctrl
// Description : SRAM front end turning partially masked writes into RMW on a
//               maskless single-port macro.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_sram_rmw_ctrl
    import mem_sram_pkg::*;
#(
    parameter int unsigned Depth   = 2048,
    parameter int unsigned Dw      = 32,
    parameter int unsigned Aw      = $clog2(Depth),
    parameter int unsigned SramLat = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_i,
    output logic                   gnt_o,
    input  logic                   we_i,
    input  logic [Aw-1:0]          addr_i,
    input  logic [Dw-1:0]          wdata_i,
    input  logic [Dw-1:0]          wmask_i,
    output logic                   rvalid_o,
    output logic [Dw-1:0]          rdata_o,
    output logic                   sram_ren_o,
    output logic                   sram_wen_o,
    output logic [Aw-1:0]          sram_addr_o,
    output logic [Dw-1:0]          sram_wdata_o,
    input  logic [Dw-1:0]          sram_rdata_i,
    output logic [c_RMW_CNT_W-1:0] rmw_cnt_o
);

    localparam logic [c_RMW_CNT_W-1:0] c_CNT_ONE = {{(c_RMW_CNT_W-1){1'b0}}, 1'b1};

    rmw_state_e             r_state;
    logic [Aw-1:0]          r_addr;
    logic [Dw-1:0]          r_wdata;
    logic [Dw-1:0]          r_mask;
    logic [c_RMW_CNT_W-1:0] r_rmw_cnt;

    req_class_e w_class;
    logic       w_accept;
    logic       w_rd;
    logic       w_full_wr;
    logic       w_part_wr;
    logic       w_rmw_wr;
    logic       w_head_valid;
    logic       w_head_rmw;

    assign gnt_o     = (r_state == IDLE) & ~rst_i;
    assign w_accept  = req_i & gnt_o;
    assign w_class   = classify_req(we_i, &wmask_i, ~|wmask_i);
    assign w_rd      = w_accept & (w_class == ReqRead);
    assign w_full_wr = w_accept & (w_class == ReqFullWr);
    assign w_part_wr = w_accept & (w_class == ReqPartWr);
    assign w_rmw_wr  = (r_state == RMW_WR);

    // The RMW read shares the macro read port with plain reads.
    assign sram_ren_o = w_rd | w_part_wr;
    assign sram_wen_o = w_full_wr | w_rmw_wr;

    always_comb begin
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        if (w_rmw_wr) begin
            sram_addr_o  = r_addr;
            sram_wdata_o = (sram_rdata_i & ~r_mask) | (r_wdata & r_mask);
        end else if (w_rd | w_part_wr | w_full_wr) begin
            sram_addr_o = addr_i;
            if (w_full_wr) begin
                sram_wdata_o = wdata_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_mask    <= '0;
            r_rmw_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_part_wr) begin
                        r_addr  <= addr_i;
                        r_wdata <= wdata_i;
                        r_mask  <= wmask_i;
                        r_state <= (SramLat == 1) ? RMW_WR : RMW_WAIT;
                    end
                end
                RMW_WAIT: r_state <= RMW_WR;
                RMW_WR: begin
                    if (!(&r_rmw_cnt)) begin
                        r_rmw_cnt <= r_rmw_cnt + c_CNT_ONE;
                    end
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Tag marks RMW reads so their returning data never shows up as rvalid.
    mem_sram_lat_pipe #(
        .DEPTH (SramLat),
        .TAG_W (1)
    ) u_lat_pipe (
        .clk     (clk_i),
        .rst     (rst_i),
        .i_valid (w_rd | w_part_wr),
        .i_tag   (w_part_wr),
        .o_valid (w_head_valid),
        .o_tag   (w_head_rmw)
    );

    assign rvalid_o  = w_head_valid & ~w_head_rmw;
    assign rdata_o   = rvalid_o ? sram_rdata_i : '0;
    assign rmw_cnt_o = r_rmw_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mem_sram_rmw_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_sram_rmw_ctrl
// Description : Scoreboard bench for mem_sram_rmw_ctrl at read latency 1 and 2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_sram_rmw_ctrl;

    typedef struct packed {
        logic [10:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    int          checks = 0;
    int          errors = 0;

    logic        req_a, we_a, gnt_a, rvalid_a, ren_a, wen_a;
    logic [10:0] addr_a, saddr_a;
    logic [31:0] wdata_a, wmask_a, rdata_a, swdata_a, rd_a;
    logic [15:0] cnt_a;

    logic        req_b, we_b, gnt_b, rvalid_b, ren_b, wen_b;
    logic [10:0] addr_b, saddr_b;
    logic [31:0] wdata_b, wmask_b, rdata_b, swdata_b, rd_b1, rd_b2;
    logic [15:0] cnt_b;

    logic [31:0] mem_a [0:2047];
    logic [31:0] mem_b [0:2047];

    logic [31:0] exp_rd_a [$];
    logic [31:0] exp_rd_b [$];
    wr_t         exp_wr_a [$];
    wr_t         exp_wr_b [$];

    always #5 clk = ~clk;

    mem_sram_rmw_ctrl #(.Depth(2048), .Dw(32), .SramLat(1)) dut_a (
        .clk_i(clk), .rst_i(rst), .req_i(req_a), .gnt_o(gnt_a), .we_i(we_a),
        .addr_i(addr_a), .wdata_i(wdata_a), .wmask_i(wmask_a),
        .rvalid_o(rvalid_a), .rdata_o(rdata_a), .sram_ren_o(ren_a), .sram_wen_o(wen_a),
        .sram_addr_o(saddr_a), .sram_wdata_o(swdata_a), .sram_rdata_i(rd_a),
        .rmw_cnt_o(cnt_a)
    );

    mem_sram_rmw_ctrl #(.Depth(2048), .Dw(32), .SramLat(2)) dut_b (
        .clk_i(clk), .rst_i(rst), .req_i(req_b), .gnt_o(gnt_b), .we_i(we_b),
        .addr_i(addr_b), .wdata_i(wdata_b), .wmask_i(wmask_b),
        .rvalid_o(rvalid_b), .rdata_o(rdata_b), .sram_ren_o(ren_b), .sram_wen_o(wen_b),
        .sram_addr_o(saddr_b), .sram_wdata_o(swdata_b), .sram_rdata_i(rd_b2),
        .rmw_cnt_o(cnt_b)
    );

    // Behavioural macros: latency 1 and latency 2.
    always @(posedge clk) begin
        if (wen_a) mem_a[saddr_a] <= swdata_a;
        if (ren_a) rd_a <= mem_a[saddr_a];
        if (wen_b) mem_b[saddr_b] <= swdata_b;
        if (ren_b) rd_b1 <= mem_b[saddr_b];
        rd_b2 <= rd_b1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    wr_t w_mon;
    always @(negedge clk) begin
        if (!rst) begin
            if (rvalid_a) begin
                if (exp_rd_a.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rvalid_a_unexpected: got rvalid=1 data %h expected no rvalid", rdata_a);
                end else chk("rdata_a", {32'd0, rdata_a}, {32'd0, exp_rd_a.pop_front()});
            end
            if (rvalid_b) begin
                if (exp_rd_b.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rvalid_b_unexpected: got rvalid=1 data %h expected no rvalid", rdata_b);
                end else chk("rdata_b", {32'd0, rdata_b}, {32'd0, exp_rd_b.pop_front()});
            end
            if (wen_a) begin
                if (exp_wr_a.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL wen_a_unexpected: got write %h<=%h expected none", saddr_a, swdata_a);
                end else begin
                    w_mon = exp_wr_a.pop_front();
                    chk("sram_wr_a", {21'd0, saddr_a, swdata_a}, {21'd0, w_mon});
                end
            end
            if (wen_b) begin
                if (exp_wr_b.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL wen_b_unexpected: got write %h<=%h expected none", saddr_b, swdata_b);
                end else begin
                    w_mon = exp_wr_b.pop_front();
                    chk("sram_wr_b", {21'd0, saddr_b, swdata_b}, {21'd0, w_mon});
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 of the cycle after the accept.
    task automatic issue(input bit b, input bit we, input logic [10:0] addr,
                         input logic [31:0] wd, input logic [31:0] mask,
                         input logic [31:0] exp, input bit push);
        int n = 0;
        if (b) begin
            req_b = 1'b1; we_b = we; addr_b = addr; wdata_b = wd; wmask_b = mask;
        end else begin
            req_a = 1'b1; we_a = we; addr_a = addr; wdata_a = wd; wmask_a = mask;
        end
        while (!(b ? gnt_b : gnt_a)) begin
            @(posedge clk); #1;
            n++;
            if (n > 20) begin
                checks++; errors++;
                $display("FAIL gnt_timeout: got no grant in %0d cycles expected grant", n);
                break;
            end
        end
        if (push) begin
            if (!we) begin
                if (b) exp_rd_b.push_back(exp); else exp_rd_a.push_back(exp);
            end else if (mask != 32'd0) begin
                if (b) exp_wr_b.push_back({addr, exp}); else exp_wr_a.push_back({addr, exp});
            end
        end
        @(posedge clk); #1;
        if (b) req_b = 1'b0; else req_a = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        time t0;
        rst = 1'b1;
        req_a = 0; we_a = 0; addr_a = 0; wdata_a = 0; wmask_a = 0;
        req_b = 0; we_b = 0; addr_b = 0; wdata_b = 0; wmask_b = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt_a", {63'd0, gnt_a}, 64'd0);
        chk("rst_gnt_b", {63'd0, gnt_b}, 64'd0);
        chk("rst_strobes_a", {60'd0, rvalid_a, ren_a, wen_a, 1'b0}, 64'd0);
        chk("rst_cnt_a", {48'd0, cnt_a}, 64'd0);
        chk("rst_bus_a", {21'd0, saddr_a, swdata_a}, 64'd0);
        chk("rst_rdata_a", {32'd0, rdata_a}, 64'd0);
        rst = 1'b0;
        #1;
        chk("release_gnt_a", {63'd0, gnt_a}, 64'd1);
        chk("release_gnt_b", {63'd0, gnt_b}, 64'd1);
        @(posedge clk); #1;

        // Read latency 1
        issue(0, 1, 11'h010, 32'hDEADBEEF, 32'hFFFFFFFF, 32'hDEADBEEF, 1);
        issue(0, 0, 11'h010, 32'h0, 32'h0, 32'hDEADBEEF, 1);
        chk("lat1_rvalid", {63'd0, rvalid_a}, 64'd1);
        chk("lat1_rdata", {32'd0, rdata_a}, {32'd0, 32'hDEADBEEF});
        chk("lat1_gnt", {63'd0, gnt_a}, 64'd1);
        @(posedge clk); #1;
        chk("lat1_rvalid_pulse", {63'd0, rvalid_a}, 64'd0);

        // Byte RMW
        issue(0, 1, 11'h020, 32'h11223344, 32'hFFFFFFFF, 32'h11223344, 1);
        issue(0, 1, 11'h020, 32'h000000AA, 32'h000000FF, 32'h112233AA, 1);
        chk("rmw_gnt_low", {63'd0, gnt_a}, 64'd0);
        chk("rmw_wen", {63'd0, wen_a}, 64'd1);
        @(posedge clk); #1;
        chk("rmw_gnt_back", {63'd0, gnt_a}, 64'd1);
        chk("rmw_cnt_1", {48'd0, cnt_a}, 64'd1);
        issue(0, 0, 11'h020, 32'h0, 32'h0, 32'h112233AA, 1);

        // Null write, then back-to-back full writes
        issue(0, 1, 11'h040, 32'hFFFFFFFF, 32'h0, 32'h0, 1);
        t0 = $time;
        issue(0, 1, 11'h040, 32'hA0A0A0A0, 32'hFFFFFFFF, 32'hA0A0A0A0, 1);
        issue(0, 1, 11'h041, 32'hA1A1A1A1, 32'hFFFFFFFF, 32'hA1A1A1A1, 1);
        issue(0, 1, 11'h042, 32'hA2A2A2A2, 32'hFFFFFFFF, 32'hA2A2A2A2, 1);
        chk("b2b_cycles", 64'($time - t0), 64'd30);
        issue(0, 0, 11'h041, 32'h0, 32'h0, 32'hA1A1A1A1, 1);

        // Latency 2 RMW with a read in flight
        issue(1, 1, 11'h030, 32'hAAAABBBB, 32'hFFFFFFFF, 32'hAAAABBBB, 1);
        issue(1, 0, 11'h030, 32'h0, 32'h0, 32'hAAAABBBB, 1);
        issue(1, 1, 11'h030, 32'h55550000, 32'hFFFF0000, 32'h5555BBBB, 1);
        chk("lat2_read_rvalid", {63'd0, rvalid_b}, 64'd1);
        chk("lat2_read_old", {32'd0, rdata_b}, {32'd0, 32'hAAAABBBB});
        chk("lat2_gnt_t2", {63'd0, gnt_b}, 64'd0);
        @(posedge clk); #1;
        chk("lat2_gnt_t3", {63'd0, gnt_b}, 64'd0);
        chk("lat2_no_rvalid", {63'd0, rvalid_b}, 64'd0);
        chk("lat2_wen_t3", {63'd0, wen_b}, 64'd1);
        @(posedge clk); #1;
        chk("lat2_gnt_back", {63'd0, gnt_b}, 64'd1);
        chk("lat2_cnt", {48'd0, cnt_b}, 64'd1);
        issue(1, 0, 11'h030, 32'h0, 32'h0, 32'h5555BBBB, 1);
        repeat (4) @(posedge clk);
        #1;

        // Reset during the merged-write cycle
        issue(0, 1, 11'h050, 32'h12345678, 32'hFFFFFFFF, 32'h12345678, 1);
        issue(0, 1, 11'h050, 32'h00000099, 32'h000000FF, 32'h0, 0);
        rst = 1'b1;
        #1;
        chk("midrst_wen", {63'd0, wen_a}, 64'd0);
        chk("midrst_gnt", {63'd0, gnt_a}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("midrst_gnt_after", {63'd0, gnt_a}, 64'd1);
        @(posedge clk); #1;
        issue(0, 0, 11'h050, 32'h0, 32'h0, 32'h12345678, 1);

        // Counter saturation
        issue(0, 1, 11'h060, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 1);
        force dut_a.r_rmw_cnt = 16'hFFFD;
        #1;
        release dut_a.r_rmw_cnt;
        @(posedge clk); #1;
        issue(0, 1, 11'h060, 32'h000000A1, 32'h000000FF, 32'h000000A1, 1);
        @(posedge clk); #1;
        chk("sat_cnt_fffe", {48'd0, cnt_a}, 64'h000000000000FFFE);
        issue(0, 1, 11'h060, 32'h0000B200, 32'h0000FF00, 32'h0000B2A1, 1);
        issue(0, 1, 11'h060, 32'h00C30000, 32'h00FF0000, 32'h00C3B2A1, 1);
        @(posedge clk); #1;
        chk("sat_cnt_ffff", {48'd0, cnt_a}, 64'h000000000000FFFF);
        issue(0, 0, 11'h060, 32'h0, 32'h0, 32'h00C3B2A1, 1);

        repeat (5) @(posedge clk);
        #1;
        chk("drain_rd_a", 64'(exp_rd_a.size()), 64'd0);
        chk("drain_rd_b", 64'(exp_rd_b.size()), 64'd0);
        chk("drain_wr_a", 64'(exp_wr_a.size()), 64'd0);
        chk("drain_wr_b", 64'(exp_wr_b.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
